ps2_receiver: RTL and testbench

Receive-only PS/2 keyboard interface that fills the slot currently tied off in the control path: it turns the raw `ps2a_clk`/`ps2a_dat` lines into validated bytes on `rx_dat`/`rx_stb`, which feed `ps2_rx_dat`/`ps2_rx_stb` of `fpga_robots_game_control`. It synchronizes and deglitches both lines and decodes the 11-bit PS/2 device-to-host frame. It reports parity, framing and timeout errors. It can also inhibit the keyboard by holding the clock line low.

---
 rtl/ps2_receiver.sv | 161 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// Receive-only PS/2 keyboard port: deglitches the pad lines, decodes 11-bit
// device-to-host frames into bytes, and can inhibit the keyboard via the clock line.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a start bit (falling clock edge with data low)
// S_DATA    | shifting in D0..D7, then capturing the parity bit
// S_STOP    | waiting for the stop bit; delivers the byte or flags an error
// S_INHIBIT | clock line held low by the host; keyboard edges ignored
// S_RELEASE | clock released, waiting for the filtered clock to read high

module ps2_receiver #(
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT_TICKS = 333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sixus,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       hold,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_INHIBIT,
        S_RELEASE
    } state_t;

    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [9:0] TO_LAST   = 10'(TIMEOUT_TICKS - 1);

    // index 0 is the PS/2 clock line, index 1 the data line
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [7:0] fcnt [2];
    logic       clk_f_d;
    logic       fe;
    logic       dat_f;

    state_t     state;
    logic [3:0] bc;
    logic [7:0] sr;
    logic       par;
    logic [9:0] to_cnt;

    assign raw        = {ps2_dat_in, ps2_clk_in};
    assign dat_f      = filt[1];
    assign ps2_dat_oe = 1'b0;

    // A line must disagree with its filtered level for FILTER_LEN cycles in a row to flip it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
            clk_f_d <= 1'b1;
            fe      <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            clk_f_d <= filt[0];
            fe      <= clk_f_d & ~filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bc         <= '0;
            sr         <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_dat     <= '0;
            rx_stb     <= 1'b0;
            rx_err     <= 1'b0;
            ps2_clk_oe <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hold) begin
                        state      <= S_INHIBIT;
                        ps2_clk_oe <= 1'b1;
                    end else if (fe && !dat_f) begin
                        state  <= S_DATA;
                        bc     <= '0;
                        to_cnt <= '0;
                    end
                end
                S_DATA, S_STOP: begin
                    if (fe) begin
                        to_cnt <= '0;
                        if (state == S_DATA) begin
                            if (bc == 4'd8) begin
                                par   <= dat_f;
                                state <= S_STOP;
                            end else begin
                                sr <= {dat_f, sr[7:1]};
                                bc <= bc + 4'd1;
                            end
                        end else begin
                            if (dat_f && (^sr ^ par)) begin
                                rx_dat <= sr;
                                rx_stb <= 1'b1;
                            end else begin
                                rx_err <= 1'b1;
                            end
                            state      <= hold ? S_INHIBIT : S_IDLE;
                            ps2_clk_oe <= hold;
                        end
                    end else if (sixus) begin
                        if (to_cnt == TO_LAST) begin
                            rx_err     <= 1'b1;
                            to_cnt     <= '0;
                            state      <= hold ? S_INHIBIT : S_IDLE;
                            ps2_clk_oe <= hold;
                        end else begin
                            to_cnt <= to_cnt + 10'd1;
                        end
                    end
                end
                S_INHIBIT: begin
                    if (!hold) begin
                        ps2_clk_oe <= 1'b0;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (filt[0]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: drives scaled-down PS/2 frames and checks
// bytes, error pulses, timeout, glitch rejection, inhibit and reset.

module tb_ps2_receiver;

    localparam int HALF = 40;

    logic       clk;
    logic       rst_n;
    logic       sixus;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       hold;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int stb_cyc = 0;
    int oe_rise_cyc = 0;
    int sixus_cnt = 0;
    int err_tick = 0;
    int last_fall_tick = 0;
    int viol = 0;
    logic prev_stb = 1'b0;
    logic prev_err = 1'b0;
    logic prev_oe = 1'b0;
    int div = 0;

    ps2_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sixus      (sixus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .hold       (hold),
        .rx_dat     (rx_dat),
        .rx_stb     (rx_stb),
        .rx_err     (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle sixus pulse every 16 clocks, changed well away from the edges
    always @(posedge clk) begin
        #2;
        sixus = (div == 15);
        div = (div == 15) ? 0 : div + 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (sixus) sixus_cnt++;
        if (rx_stb) begin
            stb_cnt++;
            stb_cyc = cyc;
        end
        if (rx_err) begin
            err_cnt++;
            err_tick = sixus_cnt;
        end
        if ((rx_stb && rx_err) || (rx_stb && prev_stb) || (rx_err && prev_err)) viol++;
        if (ps2_clk_oe && !prev_oe) oe_rise_cyc = cyc;
        prev_stb = rx_stb;
        prev_err = rx_err;
        prev_oe  = ps2_clk_oe;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // nbits clock pulses of a frame; parity optionally flipped, optional clock
    // glitch before bit glitch_bit and hold raised at bit hold_bit
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input int nbits,
                              input int glitch_bit, input int hold_bit);
        logic [10:0] bits;
        bits = {1'b1, ~(^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == hold_bit) hold = 1'b1;
            ps2_dat_in = bits[i];
            if (i == glitch_bit) begin
                ps2_clk_in = 1'b0;
                tick(3);
                ps2_clk_in = 1'b1;
            end
            tick(HALF);
            ps2_clk_in = 1'b0;
            last_fall_tick = sixus_cnt;
            tick(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_dat_in = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic par_flip,
                                input int glitch_bit, input logic [7:0] exp_dat,
                                input int exp_stb, input int exp_err);
        int s0, e0;
        s0 = stb_cnt;
        e0 = err_cnt;
        send_frame(d, par_flip, 11, glitch_bit, -1);
        check_val({tag, "_stb"}, stb_cnt - s0, exp_stb);
        check_val({tag, "_err"}, err_cnt - e0, exp_err);
        check_val({tag, "_dat"}, rx_dat, exp_dat);
    endtask

    initial begin
        int s0, e0, waited;
        rst_n      = 1'b0;
        sixus      = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        hold       = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);

        check_val("rst_dat", rx_dat, 8'h00);
        check_val("rst_stb", rx_stb, 1'b0);
        check_val("rst_err", rx_err, 1'b0);
        check_val("rst_clk_oe", ps2_clk_oe, 1'b0);
        check_val("rst_dat_oe", ps2_dat_oe, 1'b0);

        expect_frame("good_1c", 8'h1C, 1'b0, -1, 8'h1C, 1, 0);
        expect_frame("good_f0", 8'hF0, 1'b0, -1, 8'hF0, 1, 0);
        expect_frame("par_err", 8'h1C, 1'b1, -1, 8'hF0, 0, 1);
        expect_frame("after_par", 8'h1C, 1'b0, -1, 8'h1C, 1, 0);

        // timeout: start + 4 data bits, then the clock idles high
        s0 = stb_cnt;
        e0 = err_cnt;
        send_frame(8'hF0, 1'b0, 5, -1, -1);
        waited = 0;
        while (err_cnt == e0 && waited < 8000) begin
            tick(1);
            waited++;
        end
        check_val("to_fired", err_cnt - e0, 1);
        check_val("to_no_stb", stb_cnt - s0, 0);
        check_val("to_ticks", (err_tick - last_fall_tick >= 332) && (err_tick - last_fall_tick <= 334), 1);
        tick(10);
        expect_frame("after_to", 8'h1C, 1'b0, -1, 8'h1C, 1, 0);
        expect_frame("good_f0b", 8'hF0, 1'b0, -1, 8'hF0, 1, 0);

        // short clock glitches in idle and mid-frame
        s0 = stb_cnt;
        e0 = err_cnt;
        ps2_clk_in = 1'b0;
        tick(3);
        ps2_clk_in = 1'b1;
        tick(HALF);
        check_val("glitch_idle", (stb_cnt - s0) + (err_cnt - e0), 0);
        expect_frame("glitch_mid", 8'h1C, 1'b0, 3, 8'h1C, 1, 0);

        // long pulse with data high is a real edge but not a start bit
        s0 = stb_cnt;
        e0 = err_cnt;
        ps2_clk_in = 1'b0;
        tick(9);
        ps2_clk_in = 1'b1;
        tick(HALF);
        check_val("long_pulse", (stb_cnt - s0) + (err_cnt - e0), 0);
        expect_frame("after_pulse", 8'hF0, 1'b0, -1, 8'hF0, 1, 0);

        // hold response in idle
        hold = 1'b1;
        check_val("oe_before", ps2_clk_oe, 1'b0);
        tick(1);
        check_val("oe_rise", ps2_clk_oe, 1'b1);
        hold = 1'b0;
        tick(1);
        check_val("oe_fall", ps2_clk_oe, 1'b0);
        tick(4);

        // hold raised mid-frame still delivers the byte
        s0 = stb_cnt;
        send_frame(8'h1C, 1'b0, 11, -1, 6);
        check_val("hold_stb", stb_cnt - s0, 1);
        check_val("hold_dat", rx_dat, 8'h1C);
        check_val("hold_oe", ps2_clk_oe, 1'b1);
        check_val("hold_oe_lat", (oe_rise_cyc >= stb_cyc) && (oe_rise_cyc <= stb_cyc + 1), 1);

        expect_frame("inhibit", 8'hF0, 1'b0, -1, 8'h1C, 0, 0);
        check_val("inhibit_oe", ps2_clk_oe, 1'b1);
        hold = 1'b0;
        tick(1);
        check_val("release_oe", ps2_clk_oe, 1'b0);
        tick(5);
        expect_frame("resume", 8'hF0, 1'b0, -1, 8'hF0, 1, 0);

        // reset in the middle of a frame
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 7, -1, -1);
        rst_n = 1'b0;
        tick(2);
        check_val("mrst_dat", rx_dat, 8'h00);
        check_val("mrst_oe", ps2_clk_oe, 1'b0);
        rst_n = 1'b1;
        tick(5);
        check_val("mrst_dat_after", rx_dat, 8'h00);
        check_val("mrst_no_err", err_cnt - e0, 0);
        expect_frame("after_rst", 8'hF0, 1'b0, -1, 8'hF0, 1, 0);

        check_val("strobe_rules", viol, 0);
        check_val("dat_oe_low", ps2_dat_oe, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
